arm_mc_ctrl: RTL

Multi-cycle control unit for the next-generation ARM core, replacing the single-cycle controller/datapath pairing with a shared-memory, multi-cycle datapath. It decodes Instr[31:12], sequences the datapath through a 10-state FSM and holds the architectural NZCV flags. Conditional execution is applied to every architectural write. A parametrised memory-wait handshake lets the core run against single-cycle BRAM or a stalling memory.

---
 rtl/arm_mc_ctrl_if.sv | 40 ++++
 rtl/arm_mc_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// arm_mc_ctrl_if
//   Bundle between the multi-cycle controller and its datapath.
//   Datapath -> controller : Instr[31:12] (as [19:0]), ALUFlags {N,Z,C,V},
//                            MemReady.
//   Controller -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
//                            ALUControl.
//   master : the controller side (drives the control word).
//   slave  : the datapath side (drives instruction, flags, memory ready).
// ---------------------------------------------------------------------------
interface arm_mc_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;

  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/arm_mc_ctrl.sv
// ---------------------------------------------------------------------------
// arm_mc_ctrl
//   Multi-cycle ARM control unit: 10-state sequencer, instruction decode of
//   Instr[31:12], architectural NZCV flags and condition evaluation.
//
//   Ports:
//     Clk    in   clock, rising edge
//     Rst    in   synchronous active-high reset; also masks all write strobes
//     bus    --   arm_mc_ctrl_if.master (instruction/flags/ready in,
//                 datapath control word out)
//     State  out  current sequencer state (debug), zero-extended to STATE_W
//
//   Parameters:
//     HAS_MEM_STALL  1: FETCH/MEMREAD/MEMWRITE wait on MemReady
//                    0: MemReady ignored, every access completes at once
//     STATE_W        width of the State debug port (>= 4)
//
//   The control word is a decode of the registered state. Strobes are then
//   qualified in the same cycle by MemReady, CondEx and Rst, which is why
//   they cannot themselves be flopped: a stalled FETCH or a failed condition
//   must suppress the write in the very cycle it happens.
// ---------------------------------------------------------------------------
module arm_mc_ctrl #(
  parameter int HAS_MEM_STALL = 1,
  parameter int STATE_W       = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  arm_mc_ctrl_if.master      bus,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // -------------------------------------------------------------------------
  // Instruction fields (Instr[31:12] arrives as bus.Instr[19:0])
  // -------------------------------------------------------------------------
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic       unused_rn;

  assign cond     = bus.Instr[19:16];
  assign op       = bus.Instr[15:14];
  assign funct    = bus.Instr[13:8];
  assign rd       = bus.Instr[3:0];
  assign rd_is_pc = (rd == 4'd15);
  // Rn is routed by the datapath through RegSrc; the controller never looks at it.
  assign unused_rn = ^bus.Instr[7:4];

  // Memory handshake; with no stalling memory every access completes at once.
  logic mem_rdy;
  assign mem_rdy = (HAS_MEM_STALL != 0) ? bus.MemReady : 1'b1;

  // -------------------------------------------------------------------------
  // State and flags
  // -------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign State = STATE_W'(state_q);

  // -------------------------------------------------------------------------
  // Condition check against the stored flags
  // -------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;                            // EQ
      4'b0001: cond_ex = ~flag_z;                           // NE
      4'b0010: cond_ex = flag_c;                            // CS
      4'b0011: cond_ex = ~flag_c;                           // CC
      4'b0100: cond_ex = flag_n;                            // MI
      4'b0101: cond_ex = ~flag_n;                           // PL
      4'b0110: cond_ex = flag_v;                            // VS
      4'b0111: cond_ex = ~flag_v;                           // VC
      4'b1000: cond_ex = flag_c & ~flag_z;                  // HI
      4'b1001: cond_ex = ~flag_c | flag_z;                  // LS
      4'b1010: cond_ex = (flag_n == flag_v);                // GE
      4'b1011: cond_ex = (flag_n != flag_v);                // LT
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);      // GT
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);       // LE
      4'b1110: cond_ex = 1'b1;                              // AL
      default: cond_ex = 1'b0;                              // 1111: never
    endcase
  end

  // -------------------------------------------------------------------------
  // Data-processing decode: ALU op, CMP suppression, which flags are written
  // -------------------------------------------------------------------------
  logic [1:0] dp_alu;
  logic       dp_no_write;
  logic       dp_upd_nzcv;
  logic       dp_upd_nz;

  always_comb begin
    dp_alu      = ALU_ADD;
    dp_no_write = 1'b0;
    dp_upd_nzcv = 1'b0;
    dp_upd_nz   = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; dp_upd_nzcv = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_upd_nzcv = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; dp_upd_nz   = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_upd_nz   = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_upd_nzcv = 1'b1; dp_no_write = 1'b1; end
      // Unsupported codes still sequence as an add but leave the flags alone.
      default: dp_alu = ALU_ADD;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer: next state, flag update and control word
  // -------------------------------------------------------------------------
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_control;
  logic       flags_we;

  // Flags only move on the execute edge of a passing S-suffixed instruction.
  assign flags_we = funct[0] & cond_ex;

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle; it is only committed with the word.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_rdy) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        // Second PC+4 gives PC+8 for any R15 operand read this cycle.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end

      S_MEMWRITE: begin
        // Strobe stays up across wait states so the memory sees a stable request.
        adr_src   = 1'b1;
        mem_write = cond_ex;
        if (mem_rdy) state_d = S_FETCH;
      end

      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ex;
        pc_write   = cond_ex & rd_is_pc;
        state_d    = S_FETCH;
      end

      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = dp_alu;
        if (flags_we) begin
          if (dp_upd_nzcv)    flags_d = bus.ALUFlags;
          else if (dp_upd_nz) flags_d = {bus.ALUFlags[3:2], flags_q[1:0]};
        end
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = cond_ex & ~dp_no_write;
        pc_write   = cond_ex & ~dp_no_write & rd_is_pc;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Reset masks every architectural write in the cycle it is asserted.
    if (Rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.PCWrite    = pc_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

endmodule
